// File: rtl/jtag_scan_chain.sv
// jtag_scan_chain: IR / user-DR / BYPASS scan chains driven by external TAP
// state decodes. Optional feature macro: JTAG_IDCODE_EN adds a 32-bit
// read-only IDCODE chain selected by IDCODE_OP, which also becomes the reset
// instruction. Without it, IDCODE_OP decodes as BYPASS and the reset
// instruction is all-ones.
// Note: i_trst_n is active-high despite its name.
module jtag_scan_chain #(
    parameter int                IR_W       = 4,
    parameter int                DR_W       = 32,
    parameter int                N_DR       = 4,
    parameter logic [IR_W-1:0]   IR_CAPTURE = 4'b0101,
    parameter logic [31:0]       IDCODE     = 32'h1000_0001,
    parameter logic [IR_W-1:0]   IDCODE_OP  = 4'hE
) (
    input  logic                 i_tclk,
    input  logic                 i_trst_n,
    input  logic                 i_tdi,
    output logic                 o_tdo,
    input  logic                 i_stateIsTestLogicReset,
    input  logic                 i_stateIsCaptureIr,
    input  logic                 i_stateIsShiftIr,
    input  logic                 i_stateIsUpdateIr,
    input  logic                 i_stateIsCaptureDr,
    input  logic                 i_stateIsShiftDr,
    input  logic                 i_stateIsUpdateDr,
    input  logic [N_DR*DR_W-1:0] i_dataReg,
    output logic [IR_W-1:0]      o_ir,
    output logic [N_DR-1:0]      o_drWrite,
    output logic [DR_W-1:0]      o_drData,
    output logic                 o_bypassSel
);

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] RST_IR = IDCODE_OP;
`else
    localparam logic [IR_W-1:0] RST_IR = '1;
`endif

    logic [IR_W-1:0] ir_chain_q, ir_chain_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [DR_W-1:0] dr_q, dr_d;
    logic            byp_q, byp_d;
    logic [N_DR-1:0] drw_q, drw_d;
    logic [DR_W-1:0] drd_q, drd_d;

    // Exactly one action per edge; TLR beats capture beats shift beats
    // update, and within each class IR beats DR.
    logic act_tlr, act_cir, act_cdr, act_sir, act_sdr, act_uir, act_udr;
    assign act_tlr = i_stateIsTestLogicReset;
    assign act_cir = !act_tlr && i_stateIsCaptureIr;
    assign act_cdr = !act_tlr && !i_stateIsCaptureIr && i_stateIsCaptureDr;
    assign act_sir = !act_tlr && !i_stateIsCaptureIr && !i_stateIsCaptureDr
                     && i_stateIsShiftIr;
    assign act_sdr = !act_tlr && !i_stateIsCaptureIr && !i_stateIsCaptureDr
                     && !i_stateIsShiftIr && i_stateIsShiftDr;
    assign act_uir = !act_tlr && !i_stateIsCaptureIr && !i_stateIsCaptureDr
                     && !i_stateIsShiftIr && !i_stateIsShiftDr && i_stateIsUpdateIr;
    assign act_udr = !act_tlr && !i_stateIsCaptureIr && !i_stateIsCaptureDr
                     && !i_stateIsShiftIr && !i_stateIsShiftDr && !i_stateIsUpdateIr
                     && i_stateIsUpdateDr;

    // Instruction decode: low codes pick a user register, everything else
    // (including all-ones) is BYPASS unless it is the IDCODE opcode.
    logic sel_user, sel_idc;
    assign sel_user = (int'(ir_q) < N_DR);

`ifdef JTAG_IDCODE_EN
    logic [31:0] idc_q, idc_d;
    assign sel_idc = !sel_user && (ir_q == IDCODE_OP);

    // IDCODE chain: loads the constant on capture, shifts like any DR.
    always_comb begin
        idc_d = idc_q;
        if (act_cdr && sel_idc)
            idc_d = IDCODE;
        else if (act_sdr && sel_idc)
            idc_d = 32'({i_tdi, idc_q} >> 1);
    end

    // IDCODE chain register.
    always_ff @(posedge i_tclk or posedge i_trst_n) begin
        if (i_trst_n) idc_q <= '0;
        else          idc_q <= idc_d;
    end
`else
    assign sel_idc = 1'b0;
`endif

    // Capture source and update strobe for the currently selected user DR.
    logic [DR_W-1:0] cap_val;
    logic [N_DR-1:0] sel_onehot;
    always_comb begin
        cap_val    = '0;
        sel_onehot = '0;
        for (int k = 0; k < N_DR; k++) begin
            if (ir_q == IR_W'(k)) begin
                cap_val       = i_dataReg[k*DR_W +: DR_W];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state for all chains and output registers.
    always_comb begin
        ir_chain_d = ir_chain_q;
        ir_d       = ir_q;
        dr_d       = dr_q;
        byp_d      = byp_q;
        drw_d      = '0;
        drd_d      = drd_q;
        if (act_tlr) begin
            ir_d = RST_IR;
        end else if (act_cir) begin
            ir_chain_d = IR_CAPTURE;
        end else if (act_cdr) begin
            byp_d = 1'b0;
            if (sel_user) dr_d = cap_val;
        end else if (act_sir) begin
            ir_chain_d = IR_W'({i_tdi, ir_chain_q} >> 1);
        end else if (act_sdr) begin
            if (sel_user)      dr_d  = DR_W'({i_tdi, dr_q} >> 1);
            else if (!sel_idc) byp_d = i_tdi;
        end else if (act_uir) begin
            ir_d = ir_chain_q;
        end else if (act_udr) begin
            if (sel_user) begin
                drd_d = dr_q;
                drw_d = sel_onehot;
            end
        end
    end

    // State registers; reset aborts any scan in progress.
    always_ff @(posedge i_tclk or posedge i_trst_n) begin
        if (i_trst_n) begin
            ir_chain_q <= '0;
            ir_q       <= RST_IR;
            dr_q       <= '0;
            byp_q      <= 1'b0;
            drw_q      <= '0;
            drd_q      <= '0;
        end else begin
            ir_chain_q <= ir_chain_d;
            ir_q       <= ir_d;
            dr_q       <= dr_d;
            byp_q      <= byp_d;
            drw_q      <= drw_d;
            drd_q      <= drd_d;
        end
    end

    // TDO: IR bit0 while shifting IR, otherwise bit0 of the selected DR.
    always_comb begin
        if (act_sir)       o_tdo = ir_chain_q[0];
`ifdef JTAG_IDCODE_EN
        else if (sel_idc)  o_tdo = idc_q[0];
`endif
        else if (sel_user) o_tdo = dr_q[0];
        else               o_tdo = byp_q;
    end

    assign o_ir        = ir_q;
    assign o_drWrite   = drw_q;
    assign o_drData    = drd_q;
    assign o_bypassSel = !sel_user && !sel_idc;

endmodule
